// File: rtl/score_argmax_if.sv
// Score stream into the argmax stage and its decision output toward the display stage.
// The master drives scores; the slave (score_argmax) returns the decision pulse.
interface score_argmax_if #(
  parameter int W = 16
);
  logic                valid_in;
  logic signed [W-1:0] score_in;
  logic                last_in;
  logic [2:0]          decision;
  logic                valid_out;
  logic                frame_err;

  modport master (
    output valid_in, score_in, last_in,
    input  decision, valid_out, frame_err
  );

  modport slave (
    input  valid_in, score_in, last_in,
    output decision, valid_out, frame_err
  );
endinterface

// File: rtl/score_argmax.sv
// Serial argmax over one frame of signed class scores with a confidence margin.
// Best/second tracking runs per beat; the decision registers one cycle after the closing beat.
module score_argmax #(
  parameter int          W           = 16,
  parameter int          NUM_CLASSES = 2,
  parameter int unsigned MARGIN      = 0
) (
  input logic           clk,
  input logic           rst_n,
  score_argmax_if.slave bus
);
  localparam logic [2:0]          LP_NUM    = 3'(NUM_CLASSES);
  localparam logic [2:0]          LP_ERR    = 3'd7;
  localparam logic signed [W-1:0] LP_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W:0]          LP_MARGIN = (W+1)'(MARGIN);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              r_state, w_state_nxt;
  logic signed [W-1:0] r_best, w_best_nxt;
  logic signed [W-1:0] r_second, w_second_nxt;
  logic [2:0]          r_best_idx, w_best_idx_nxt;
  logic [2:0]          r_count, w_count_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                r_close;
  logic [2:0]          r_decision;
  logic                r_valid_out;
  logic                r_frame_err;
  logic [W:0]          w_margin;
  logic                w_malformed;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_best_nxt     = r_best;
    w_second_nxt   = r_second;
    w_best_idx_nxt = r_best_idx;
    w_count_nxt    = r_count;
    w_overrun_nxt  = r_overrun;
    if (bus.valid_in) begin
      if (r_state == IDLE) begin
        w_best_nxt     = bus.score_in;
        w_best_idx_nxt = 3'd0;
        w_second_nxt   = LP_MIN;
        w_count_nxt    = 3'd1;
        w_overrun_nxt  = 1'b0;
      end else begin
        // Strict compares keep the lowest index on ties.
        if (r_count >= LP_NUM) begin
          w_overrun_nxt = 1'b1;
        end else if (bus.score_in > r_best) begin
          w_second_nxt   = r_best;
          w_best_nxt     = bus.score_in;
          w_best_idx_nxt = r_count;
        end else if (bus.score_in > r_second) begin
          w_second_nxt = bus.score_in;
        end
        if (r_count != 3'd7) w_count_nxt = r_count + 3'd1;
      end
      w_state_nxt = bus.last_in ? IDLE : ACCUM;
    end
  end

  // NOTE: datapath registers are reset too, so a frame cut by reset leaves no stale close or overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_close    <= 1'b0;
    end else begin
      r_best     <= w_best_nxt;
      r_second   <= w_second_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_count    <= w_count_nxt;
      r_overrun  <= w_overrun_nxt;
      r_close    <= bus.valid_in & bus.last_in;
    end
  end

  // best >= second always holds, so the sign-extended difference is a non-negative W+1-bit value.
  assign w_margin    = {r_best[W-1], r_best} - {r_second[W-1], r_second};
  assign w_malformed = (r_count != LP_NUM) || r_overrun;

  // A next frame's first beat may update the tracking registers on this same edge;
  // the decision reads their pre-edge values, which still describe the closed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decision  <= LP_ERR;
      r_valid_out <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid_out <= r_close;
      r_frame_err <= r_close & w_malformed;
      if (r_close) begin
        if (w_malformed || (w_margin < LP_MARGIN)) r_decision <= LP_ERR;
        else                                       r_decision <= r_best_idx;
      end
    end
  end

  assign bus.decision  = r_decision;
  assign bus.valid_out = r_valid_out;
  assign bus.frame_err = r_frame_err;
endmodule
